disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DWELL_MS, default 2000, page dwell time in 1-ms ticks, legal range 1..65535.
REQ-002 Parameter FRESH_MS, default 250, duration of the freshness indication in 1-ms ticks, legal range 1..65535.
REQ-003 clk  in  1  system clock (50 MHz).
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ce1ms  in  1  1-ms tick from the 7-segment display driver, high for one clk.
REQ-006 upd  in  4  per-source update strobe, one clk per new word.
REQ-007 src_dat  in  64  four 16-bit source words; source i is bits [16i+15:16i], sampled when upd[i]=1.
REQ-008 next  in  1  manual page-advance pulse, one clk.
REQ-009 freeze  in  1  level; suppresses automatic advance.
REQ-010 dat  out  16  word to the display driver.
REQ-011 set_P  out  1  decimal-point request to the display driver, 1 = fresh data.
REQ-012 page  out  2  index of the source currently shown.
REQ-013 any_valid  out  1  at least one source has been loaded since reset.

Function
REQ-014 On upd[i], the block shall load src_dat word i into shadow register i and set sticky valid[i]; all four sources may load in the same clk.
REQ-015 Advance shall select the first valid index in the order page+1, page+2, page+3, page (mod 4); with no valid source, page shall remain unchanged.
REQ-016 The dwell counter shall increment on ce1ms; on a tick that finds it at DWELL_MS-1, the block shall advance and clear the counter.
REQ-017 On next=1, the block shall advance in that clk and clear the dwell counter.
REQ-018 A next coinciding with a dwell expiry shall produce exactly one advance.
REQ-019 While freeze=1, the dwell counter shall hold and no automatic advance shall occur; next shall still advance.
REQ-020 The dwell counter shall also clear whenever valid goes from all-zero to non-zero.
REQ-021 dat shall be registered and equal shadow[page] one clk after any load or page change, or 16'h0000 while any_valid=0.
REQ-022 On upd[page_new], where page_new is the page in effect after this clk, the freshness counter shall load FRESH_MS.
REQ-023 The freshness counter shall decrement on ce1ms while non-zero and clear on a page change without a matching upd.
REQ-024 set_P shall be 1 exactly while the freshness counter is non-zero.
REQ-025 When a page change and an upd to the old page occur in the same clk, the page change shall take effect and freshness shall clear.
REQ-026 When a page change and an upd to the new page occur in the same clk, dat shall show the new word one clk later and freshness shall load.

Reset
REQ-027 While rst_n=0, the block shall asynchronously clear shadow registers, valid, page, the dwell counter, the freshness counter, dat, set_P and any_valid to 0.
REQ-028 After rst_n deasserts mid-operation, the first upd shall be serviced in the first clk, with no residual page or freshness state.

Configuration
REQ-029 With macro DISP_ARB_AUTOSCROLL_EN defined, the dwell-based automatic advance of REQ-016, REQ-019 and REQ-020 shall be compiled in.
REQ-030 Without DISP_ARB_AUTOSCROLL_EN, the dwell counter shall be absent, pages shall change only on next, and freeze shall be ignored.

Structure
REQ-031 The shared package disp_arb_pkg shall hold NSRC=4, the 2-bit page type, and the DWELL_MS and FRESH_MS default constants.
REQ-032 The round-robin next-index search shall be one combinational sub-module, rr_next_sel (inputs valid[3:0] and cur[1:0]; outputs nxt[1:0] and found).

Verification
REQ-033 Reset, then upd=4'b0100 with word2=16'hA429 -> one clk later page=2, dat=16'hA429, any_valid=1, set_P=1; set_P=0 after 250 ticks.
REQ-034 Sources 0, 1 and 3 loaded (16'h1111, 16'h2222, 16'h4444), DWELL_MS=3, autoscroll on -> page sequence 0,1,3,0 every 3 ticks; source 2 skipped.
REQ-035 next pulse on the same clk as a dwell expiry from page 0 (sources 0 and 1 valid) -> page=1 only; dwell counter restarts at 0.
REQ-036 freeze=1 for 10 ticks with DWELL_MS=3 -> page constant; next during freeze advances one page.
REQ-037 upd[1] in the same clk that page advances 0->1 -> dat shows the new word1 and set_P=1; upd[0] in that clk instead -> set_P=0.
REQ-038 rst_n pulled low mid-dwell with set_P=1 -> dat=0, set_P=0, page=0, any_valid=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared constants and types for the display page arbiter.
package disp_arb_pkg;
   localparam int NSRC         = 4;
   localparam int DWELL_MS_DEF = 2000;
   localparam int FRESH_MS_DEF = 250;
   localparam int CNT_W        = 16;

   typedef logic [1:0] page_t;
endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first valid index in the order cur+1, cur+2, cur+3, cur.
module rr_next_sel
   import disp_arb_pkg::*;
(
   input  logic [NSRC-1:0] valid,
   input  page_t           cur,
   output page_t           nxt,
   output logic            found
);

   page_t w_idx;

   // Walk from the farthest candidate to the nearest so the nearest valid one wins.
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      w_idx = cur;
      for (int k = NSRC; k >= 1; k--) begin
         w_idx = cur + page_t'(k);
         if (valid[w_idx]) begin
            nxt   = w_idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// Four-source display page arbiter with freshness indication.
// Define DISP_ARB_AUTOSCROLL_EN to compile in the dwell-timed automatic page advance.
module disp_arbiter
   import disp_arb_pkg::*;
#(
   parameter int DWELL_MS = DWELL_MS_DEF,
   parameter int FRESH_MS = FRESH_MS_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce1ms,
   input  logic [NSRC-1:0]   upd,
   input  logic [16*NSRC-1:0] src_dat,
   input  logic              next,
   input  logic              freeze,
   output logic [15:0]       dat,
   output logic              set_P,
   output logic [1:0]        page,
   output logic              any_valid
);

   logic [15:0]      r_shadow [NSRC];
   logic [NSRC-1:0]  r_valid;
   page_t            r_page;
   logic [CNT_W-1:0] r_fresh;
   logic [15:0]      r_dat;

   logic             w_any;
   logic             w_first_load;
   logic [NSRC-1:0]  w_sel_valid;
   page_t            w_rr_nxt;
   logic             w_rr_found;
   logic             w_expire;
   logic             w_advance;
   page_t            w_page_nxt;
   logic [NSRC-1:0]  w_valid_nxt;
   logic [15:0]      w_word_nxt;

   assign w_any        = |r_valid;
   assign w_first_load = !w_any && (|upd);
   assign w_valid_nxt  = r_valid | upd;
   // Before anything is loaded, the first arriving source(s) pick the page.
   assign w_sel_valid  = w_any ? r_valid : upd;

   rr_next_sel u_rr (
      .valid (w_sel_valid),
      .cur   (r_page),
      .nxt   (w_rr_nxt),
      .found (w_rr_found)
   );

`ifdef DISP_ARB_AUTOSCROLL_EN
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_MS - 1);

   logic [CNT_W-1:0] r_dwell;

   assign w_expire = ce1ms && !freeze && (r_dwell == DWELL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell <= '0;
      end else if (next || w_first_load) begin
         r_dwell <= '0;
      end else if (ce1ms && !freeze) begin
         r_dwell <= w_expire ? '0 : r_dwell + 1'b1;
      end
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{freeze, CNT_W'(DWELL_MS)};
   assign w_expire     = 1'b0;
`endif

   // Manual and timed advance in the same clk collapse into a single step.
   assign w_advance  = next || w_expire;
   assign w_page_nxt = ((w_first_load || w_advance) && w_rr_found) ? w_rr_nxt : r_page;
   assign w_word_nxt = upd[w_page_nxt] ? src_dat[{w_page_nxt, 4'b0000} +: 16]
                                       : r_shadow[w_page_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSRC; i++) r_shadow[i] <= '0;
         r_valid <= '0;
         r_page  <= '0;
         r_dat   <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (upd[i]) r_shadow[i] <= src_dat[16*i +: 16];
         end
         r_valid <= w_valid_nxt;
         r_page  <= w_page_nxt;
         r_dat   <= (|w_valid_nxt) ? w_word_nxt : 16'h0000;
      end
   end

   // A load to the page being shown wins over a page change; otherwise a change clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fresh <= '0;
      end else if (upd[w_page_nxt]) begin
         r_fresh <= CNT_W'(FRESH_MS);
      end else if (w_page_nxt != r_page) begin
         r_fresh <= '0;
      end else if (ce1ms && (r_fresh != '0)) begin
         r_fresh <= r_fresh - 1'b1;
      end
   end

   assign dat       = r_dat;
   assign page      = r_page;
   assign set_P     = (r_fresh != '0);
   assign any_valid = w_any;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter; expectations adapt to DISP_ARB_AUTOSCROLL_EN.
module tb_disp_arbiter;

`ifdef DISP_ARB_AUTOSCROLL_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam logic [3:0] M_ALL = 4'b1111;
   localparam logic [3:0] M_PD  = 4'b1100;
   localparam logic [3:0] M_PDS = 4'b1110;

   typedef struct {
      string       tag;
      logic [3:0]  mask;
      logic [1:0]  pg;
      logic [15:0] dt;
      logic        sp;
      logic        av;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce1ms = 1'b0;
   logic [3:0]  upd = '0;
   logic [63:0] src_dat = '0;
   logic        nxt_p = 1'b0;
   logic        freeze = 1'b0;
   logic [15:0] dat;
   logic        set_P;
   logic [1:0]  page;
   logic        any_valid;

   int n_chk  = 0;
   int n_fail = 0;
   exp_t sb[$];
   exp_t e;
   logic [1:0] exp_pg;
   logic [1:0] seq [4];

   always #10 clk = ~clk;

   disp_arbiter #(.DWELL_MS(3), .FRESH_MS(250)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce1ms     (ce1ms),
      .upd       (upd),
      .src_dat   (src_dat),
      .next      (nxt_p),
      .freeze    (freeze),
      .dat       (dat),
      .set_P     (set_P),
      .page      (page),
      .any_valid (any_valid)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [1:0] p);
      case (p)
         2'd0:    return 16'h1111;
         2'd1:    return 16'h2222;
         2'd2:    return 16'hA429;
         default: return 16'h4444;
      endcase
   endfunction

   task automatic set_word(input int i, input logic [15:0] v);
      src_dat[16*i +: 16] = v;
   endtask

   task automatic cyc(input logic ce, input logic [3:0] u, input logic nx, input bit chk,
                      input string tag, input logic [3:0] m, input logic [1:0] pg,
                      input logic [15:0] dt, input logic sp, input logic av);
      exp_t x;
      @(negedge clk);
      ce1ms = ce;
      upd   = u;
      nxt_p = nx;
      if (chk) begin
         x.tag = tag; x.mask = m; x.pg = pg; x.dt = dt; x.sp = sp; x.av = av;
         sb.push_back(x);
      end
      @(posedge clk);
      #2;
      ce1ms = 1'b0;
      upd   = '0;
      nxt_p = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.mask[3]) check_eq({e.tag, ".page"},  {30'd0, page},     {30'd0, e.pg});
         if (e.mask[2]) check_eq({e.tag, ".dat"},   {16'd0, dat},      {16'd0, e.dt});
         if (e.mask[1]) check_eq({e.tag, ".set_P"}, {31'd0, set_P},    {31'd0, e.sp});
         if (e.mask[0]) check_eq({e.tag, ".any"},   {31'd0, any_valid},{31'd0, e.av});
      end
   end

   initial begin
      seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;

      // Reset state
      #5;
      check_eq("rst.page",  {30'd0, page},      32'd0);
      check_eq("rst.dat",   {16'd0, dat},       32'd0);
      check_eq("rst.set_P", {31'd0, set_P},     32'd0);
      check_eq("rst.any",   {31'd0, any_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single source load and freshness expiry
      set_word(2, 16'hA429);
      cyc(1'b0, 4'b0100, 1'b0, 1'b1, "r33_load", M_ALL, 2'd2, 16'hA429, 1'b1, 1'b1);
      for (int i = 1; i <= 250; i++)
         cyc(1'b1, 4'b0000, 1'b0, (i >= 249), (i == 249) ? "r33_fresh_hold" : "r33_fresh_end",
             M_ALL, 2'd2, 16'hA429, (i == 249), 1'b1);

      // Round-robin scroll skipping an empty source
      do_reset();
      set_word(0, 16'h1111);
      cyc(1'b0, 4'b0001, 1'b0, 1'b1, "r34_load0", M_ALL, 2'd0, 16'h1111, 1'b1, 1'b1);
      set_word(1, 16'h2222);
      set_word(3, 16'h4444);
      cyc(1'b0, 4'b1010, 1'b0, 1'b1, "r34_load13", M_ALL, 2'd0, 16'h1111, 1'b1, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         exp_pg = AUTO ? seq[k/3] : 2'd0;
         cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r34_scroll", M_PD, exp_pg, word_of(exp_pg), 1'b0, 1'b1);
      end

      // Manual advance coinciding with dwell expiry
      do_reset();
      set_word(0, 16'h1111);
      cyc(1'b0, 4'b0001, 1'b0, 1'b1, "r35_load0", M_ALL, 2'd0, 16'h1111, 1'b1, 1'b1);
      set_word(1, 16'h2222);
      cyc(1'b0, 4'b0010, 1'b0, 1'b1, "r35_load1", M_PD, 2'd0, 16'h1111, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++)
         cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r35_pre", M_PD, 2'd0, 16'h1111, 1'b0, 1'b1);
      cyc(1'b1, 4'b0000, 1'b1, 1'b1, "r35_coinc", M_ALL, 2'd1, 16'h2222, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++)
         cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r35_restart", M_PD, 2'd1, 16'h2222, 1'b0, 1'b1);
      exp_pg = AUTO ? 2'd0 : 2'd1;
      cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r35_expire", M_PD, exp_pg, word_of(exp_pg), 1'b0, 1'b1);

      // Freeze holds the page; next still advances
      freeze = 1'b1;
      for (int k = 0; k < 10; k++)
         cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r36_frozen", M_PD, exp_pg, word_of(exp_pg), 1'b0, 1'b1);
      exp_pg = exp_pg ^ 2'd1;
      cyc(1'b0, 4'b0000, 1'b1, 1'b1, "r36_next", M_PD, exp_pg, word_of(exp_pg), 1'b0, 1'b1);
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r36_frozen2", M_PD, exp_pg, word_of(exp_pg), 1'b0, 1'b1);

      // Update racing a page change: to the new page, then to the old page
      do_reset();
      set_word(0, 16'h1111);
      cyc(1'b0, 4'b0001, 1'b0, 1'b1, "r37_load0", M_ALL, 2'd0, 16'h1111, 1'b1, 1'b1);
      set_word(1, 16'h2222);
      cyc(1'b0, 4'b0010, 1'b0, 1'b0, "", M_ALL, 2'd0, 16'h0, 1'b0, 1'b0);
      set_word(1, 16'hBEEF);
      cyc(1'b0, 4'b0010, 1'b1, 1'b1, "r37_upd_new", M_ALL, 2'd1, 16'hBEEF, 1'b1, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1, 1'b1, "r37_back", M_PDS, 2'd0, 16'h1111, 1'b0, 1'b1);
      set_word(0, 16'h5555);
      cyc(1'b0, 4'b0001, 1'b1, 1'b1, "r37_upd_old", M_PDS, 2'd1, 16'hBEEF, 1'b0, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1, 1'b1, "r37_old_word", M_PDS, 2'd0, 16'h5555, 1'b0, 1'b1);

      // Asynchronous reset mid-dwell while fresh
      set_word(0, 16'h7777);
      cyc(1'b0, 4'b0001, 1'b0, 1'b1, "r38_pre", M_ALL, 2'd0, 16'h7777, 1'b1, 1'b1);
      freeze = 1'b0;
      cyc(1'b1, 4'b0000, 1'b0, 1'b1, "r38_tick", M_ALL, 2'd0, 16'h7777, 1'b1, 1'b1);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("r38_async.page",  {30'd0, page},      32'd0);
      check_eq("r38_async.dat",   {16'd0, dat},       32'd0);
      check_eq("r38_async.set_P", {31'd0, set_P},     32'd0);
      check_eq("r38_async.any",   {31'd0, any_valid}, 32'd0);

      // First update after release is serviced on the first edge
      @(posedge clk);
      #5 rst_n = 1'b1;
      set_word(3, 16'h9999);
      cyc(1'b0, 4'b1000, 1'b0, 1'b1, "r28_first_upd", M_ALL, 2'd3, 16'h9999, 1'b1, 1'b1);

      repeat (3) @(negedge clk);
      check_eq("sb_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
